// File: rtl/pipe_pkg.sv
// Shared widths and the buffer entry layout for the address pipeline stages.
// ADDRESS_WIDTH / ID_WIDTH may be supplied as defines; otherwise 8 / 4 bits are used.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 8
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

package pipe_pkg;
  localparam int ADDR_W = `ADDRESS_WIDTH;
  localparam int ID_W   = `ID_WIDTH;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic              vld;
  } pipe_entry_t;
endpackage

// File: rtl/pipeline_stage_buf.sv
// DEPTH-entry beat store: one write port, parallel ID-match invalidate, async read mux.
// A write to a slot takes priority over a kill of that slot in the same cycle.
module pipeline_stage_buf
  import pipe_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_ptr_i,
  input  pipe_entry_t      wr_entry_i,
  input  logic             kill_en_i,
  input  logic [ID_W-1:0]  kill_id_i,
  input  logic [PTR_W-1:0] rd_ptr_i,
  output pipe_entry_t      rd_entry_o
);

  pipe_entry_t mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en_i && wr_ptr_i == PTR_W'(i))
          mem_q[i] <= wr_entry_i;
        else if (kill_en_i && mem_q[i].vld && mem_q[i].id == kill_id_i)
          mem_q[i].vld <= 1'b0;
      end
    end
  end

  assign rd_entry_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/pipeline_stage_fifo.sv
// Address pipeline stage: circular skid buffer adding stage_offset, flush-by-ID, 1-cycle latency.
// out_stall asserts at DEPTH-1 entries; PIPE_STAGE_FLUSH_STALL_EN also stalls/inhibits pop around a flush.
module pipeline_stage_fifo
  import pipe_pkg::*;
#(
  parameter int ADDR_W = pipe_pkg::ADDR_W,
  parameter int ID_W   = pipe_pkg::ID_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] stage_offset,
  input  logic [ADDR_W-1:0] in_address,
  input  logic [ID_W-1:0]   in_id,
  input  logic              in_valid,
  output logic              out_stall,
  input  logic              in_flush,
  input  logic [ID_W-1:0]   in_flush_id,
  output logic [ADDR_W-1:0] out_address,
  output logic [ID_W-1:0]   out_id,
  output logic              out_valid,
  output logic              out_flush,
  output logic [ID_W-1:0]   out_flush_id,
  input  logic              in_stall,
  output logic              overflow_err,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flush_q;
  logic [ID_W-1:0]  flush_id_q;
  logic             overflow_q;

  pipe_entry_t head, wr_entry;
  logic        not_empty, full, pop_ok, pop, reclaim, advance, push, drop;

  pipeline_stage_buf #(.DEPTH(DEPTH)) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en_i    (push),
    .wr_ptr_i   (wr_ptr_q),
    .wr_entry_i (wr_entry),
    .kill_en_i  (in_flush),
    .kill_id_i  (in_flush_id),
    .rd_ptr_i   (rd_ptr_q),
    .rd_entry_o (head)
  );

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CNT_W'(DEPTH));

`ifdef PIPE_STAGE_FLUSH_STALL_EN
  // Holding the head during a flush lets a matching head be killed instead of escaping.
  assign pop_ok    = !in_stall && !in_flush;
  assign out_stall = (count_q >= CNT_W'(DEPTH-1)) || in_flush || flush_q;
`else
  assign pop_ok    = !in_stall;
  assign out_stall = (count_q >= CNT_W'(DEPTH-1));
`endif

  assign out_valid   = not_empty && head.vld;
  assign out_address = out_valid ? head.addr : '0;
  assign out_id      = out_valid ? head.id   : '0;

  // Killed holes at the head drain one per cycle even while downstream stalls.
  assign pop     = out_valid && pop_ok;
  assign reclaim = not_empty && !head.vld;
  assign advance = pop || reclaim;
  assign push    = in_valid && (!full || advance);
  assign drop    = in_valid && full && !advance;

  assign wr_entry.addr = in_address + stage_offset;
  assign wr_entry.id   = in_id;
  assign wr_entry.vld  = !(in_flush && (in_id == in_flush_id));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push)    wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (advance) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(advance);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      flush_id_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      flush_q    <= in_flush;
      flush_id_q <= in_flush_id;
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign out_flush    = flush_q;
  assign out_flush_id = flush_id_q;
  assign overflow_err = overflow_q;
  assign occupancy    = count_q;

endmodule

// File: tb/tb_pipeline_stage_fifo.sv
// Directed + random bench for pipeline_stage_fifo against a queue-based reference model.
module tb_pipeline_stage_fifo;
  import pipe_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] stage_offset, in_address, out_address;
  logic [ID_W-1:0]   in_id, in_flush_id, out_id, out_flush_id;
  logic              in_valid, out_stall, in_flush, out_valid, out_flush, in_stall, overflow_err;
  logic [CNT_W-1:0]  occupancy;

  always #5 clk = ~clk;

  pipeline_stage_fifo #(.ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .stage_offset(stage_offset),
    .in_address(in_address), .in_id(in_id), .in_valid(in_valid), .out_stall(out_stall),
    .in_flush(in_flush), .in_flush_id(in_flush_id),
    .out_address(out_address), .out_id(out_id), .out_valid(out_valid),
    .out_flush(out_flush), .out_flush_id(out_flush_id),
    .in_stall(in_stall), .overflow_err(overflow_err), .occupancy(occupancy)
  );

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [ID_W-1:0]   id;
    bit                v;
  } ment_t;

  ment_t           mq[$];
  bit              m_ovf, m_fl;
  logic [ID_W-1:0] m_fid;
  int              n_chk = 0;
  int              n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    bit ev, es;
    ev = (mq.size() > 0) && mq[0].v;
    es = (mq.size() >= DEPTH-1);
`ifdef PIPE_STAGE_FLUSH_STALL_EN
    es = es || in_flush || m_fl;
`endif
    chk({tag, ".valid"},   32'(out_valid),    32'(ev));
    chk({tag, ".addr"},    32'(out_address),  ev ? 32'(mq[0].a)  : 32'd0);
    chk({tag, ".id"},      32'(out_id),       ev ? 32'(mq[0].id) : 32'd0);
    chk({tag, ".occ"},     32'(occupancy),    32'(mq.size()));
    chk({tag, ".stall"},   32'(out_stall),    32'(es));
    chk({tag, ".ovf"},     32'(overflow_err), 32'(m_ovf));
    chk({tag, ".flush"},   32'(out_flush),    32'(m_fl));
    chk({tag, ".flushid"}, 32'(out_flush_id), 32'(m_fid));
  endtask

  // Queue semantics: front leaves on delivery or if dead, flush kills survivors, then append.
  task automatic model_step();
    bit    pop, adv;
    ment_t e;
    pop = (mq.size() > 0) && mq[0].v && !in_stall;
`ifdef PIPE_STAGE_FLUSH_STALL_EN
    if (in_flush) pop = 1'b0;
`endif
    adv = pop || ((mq.size() > 0) && !mq[0].v);
    if (adv) void'(mq.pop_front());
    if (in_flush)
      foreach (mq[i]) if (mq[i].v && mq[i].id == in_flush_id) mq[i].v = 1'b0;
    if (in_valid) begin
      if (mq.size() < DEPTH) begin
        e.a  = in_address + stage_offset;
        e.id = in_id;
        e.v  = !(in_flush && in_id == in_flush_id);
        mq.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
    m_fl  = in_flush;
    m_fid = in_flush_id;
  endtask

  task automatic cycle(input string tag, input logic v, input logic [ADDR_W-1:0] a,
                       input logic [ID_W-1:0] id, input logic fl,
                       input logic [ID_W-1:0] fid, input logic st);
    in_valid = v; in_address = a; in_id = id;
    in_flush = fl; in_flush_id = fid; in_stall = st;
    #1;
    check_outputs(tag);
    model_step();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_flush = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; stage_offset = '0; in_address = '0; in_id = '0;
    in_valid = 1'b0; in_flush = 1'b0; in_flush_id = '0; in_stall = 1'b0;
    m_ovf = 1'b0; m_fl = 1'b0; m_fid = '0;
    #1;
    check_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Pass-through with offset
    stage_offset = 8'h10;
    cycle("push1", 1, 8'h20, 4'd3, 0, 0, 0);
    chk("pass.addr", 32'(out_address), 32'h30);
    chk("pass.id",   32'(out_id),      32'd3);
    chk("pass.vld",  32'(out_valid),   32'd1);
    for (int i = 0; i < 8; i++) cycle("stream", 1, ADDR_W'(8'h40 + i), ID_W'(i), 0, 0, 0);
    repeat (3) cycle("drain0", 0, 0, 0, 0, 0, 0);

    // Fill against downstream stall, then overflow
    for (int i = 1; i <= 4; i++) begin
      cycle("fill", 1, ADDR_W'(i), ID_W'(i), 0, 0, 1);
      if (i == 3) chk("fill.stall3", 32'(out_stall), 32'd1);
    end
    chk("fill.occ", 32'(occupancy), 32'd4);
    cycle("ovf", 1, 8'h55, 4'd5, 0, 0, 1);
    chk("ovf.sticky", 32'(overflow_err), 32'd1);
    for (int i = 0; i < 5; i++) cycle("drain1", 0, 0, 0, 0, 0, 0);

    // Mid-buffer flush leaves holes that drain silently
    cycle("mf1", 1, 8'h01, 4'd1, 0, 0, 1);
    cycle("mf2", 1, 8'h02, 4'd2, 0, 0, 1);
    cycle("mf3", 1, 8'h03, 4'd1, 0, 0, 1);
    cycle("mf4", 1, 8'h04, 4'd3, 0, 0, 1);
    cycle("mfk", 0, 0, 0, 1, 4'd1, 1);
    chk("mf.occ", 32'(occupancy), 32'd4);
    for (int i = 0; i < 6; i++) cycle("mfdrain", 0, 0, 0, 0, 0, 0);

    // Incoming beat killed in its own cycle
    cycle("sc", 1, 8'h11, 4'd5, 1, 4'd5, 0);
    chk("sc.vld", 32'(out_valid), 32'd0);
    chk("sc.occ", 32'(occupancy), 32'd1);
    cycle("sc2", 0, 0, 0, 0, 0, 0);
    chk("sc2.occ", 32'(occupancy), 32'd0);

    // Address carry discarded
    cycle("wrap", 1, 8'hF8, 4'd6, 0, 0, 0);
    chk("wrap.addr", 32'(out_address), 32'h08);
    cycle("wrap2", 0, 0, 0, 0, 0, 0);

    // Flush propagation; head id 7 flushed while unstalled
    cycle("fp0", 1, 8'h70, 4'd7, 0, 0, 0);
    cycle("fp1", 0, 0, 0, 1, 4'd7, 0);
    chk("fp.flush",   32'(out_flush),    32'd1);
    chk("fp.flushid", 32'(out_flush_id), 32'd7);
    for (int i = 0; i < 3; i++) cycle("fp2", 0, 0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      stage_offset = ADDR_W'($urandom);
      cycle("rnd", 1'($urandom_range(0, 3) != 0), ADDR_W'($urandom), ID_W'($urandom_range(0, 3)),
            1'($urandom_range(0, 7) == 0), ID_W'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < 2 * DEPTH + 2; i++) cycle("rdrain", 0, 0, 0, 0, 0, 0);

    // Reset in the middle of traffic
    cycle("mr1", 1, 8'hA1, 4'd1, 0, 0, 1);
    cycle("mr2", 1, 8'hA2, 4'd2, 0, 0, 1);
    reset_n = 1'b0;
    #1;
    mq.delete(); m_ovf = 1'b0; m_fl = 1'b0; m_fid = '0;
    check_outputs("midrst");
    @(posedge clk);
    #1 reset_n = 1'b1;
    cycle("post", 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
